// File: rtl/hc283_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_e : FSM state encoding (IDLE, RUN, DONE)
//   SLICE_W : width of the single time-multiplexed adder slice
package hc283_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

endpackage

// File: rtl/hc283_serial_adder_if.sv
// Handshake/data bundle for hc283_serial_adder.
//   Input side : in_valid, in_ready, inA, inB, cin, op_sub
//   Output side: out_valid, out_ready, out, cout, ovf, busy
//   master modport: the producer/consumer environment
//   slave modport : the adder itself
interface hc283_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, inA, inB, cin, op_sub, out_ready,
    input  in_ready, out_valid, out, cout, ovf, busy
  );

  modport slave (
    input  in_valid, inA, inB, cin, op_sub, out_ready,
    output in_ready, out_valid, out, cout, ovf, busy
  );
endinterface

// File: rtl/hc283_slice4.sv
// Combinational 4-bit adder slice: {co, s} = a + b + ci.
//   a, b : slice operands
//   ci   : carry in
//   s    : slice sum
//   co   : carry out
module hc283_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

// File: rtl/hc283_serial_adder.sv
// Nibble-serial WIDTH-bit adder. One 4-bit slice is reused for every
// nibble; the carry ripples between cycles through carry_q.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hc283_serial_adder_if.slave (operand handshake, result handshake,
//           out/cout/ovf, busy)
// Optional macro HC283_SERIAL_SUB_EN: when defined, op_sub=1 computes A-B by
// latching ~inB and forcing the slice-0 carry to 1. When undefined op_sub is
// ignored.
module hc283_serial_adder
  import hc283_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hc283_serial_adder_if.slave  bus
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;   // effective B (already inverted for subtract)
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       slice_s;
  logic             slice_co;

  hc283_slice4 u_slice (
    .a  (a_q[idx_q*SLICE_W +: SLICE_W]),
    .b  (b_q[idx_q*SLICE_W +: SLICE_W]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

`ifndef HC283_SERIAL_SUB_EN
  logic unused_op_sub;
  assign unused_op_sub = bus.op_sub;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d   = bus.inA;
`ifdef HC283_SERIAL_SUB_EN
          b_d     = bus.op_sub ? ~bus.inB : bus.inB;
          carry_d = bus.op_sub ? 1'b1 : bus.cin;
`else
          b_d     = bus.inB;
          carry_d = bus.cin;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_co;
          // Signed overflow: operands agree in sign but the sum does not.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out       = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule
